// File: rtl/key_hit_judge_pkg.sv
// Shared definitions for the piano-tiles key judge: default geometry, debounce
// length and the judge FSM state encoding.
package key_hit_judge_pkg;

  localparam int LANES_DEF           = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int SCORE_W_DEF         = 8;
  localparam int MAX_MISSES_DEF      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_OVER  = 2'd2
  } judge_state_e;

  typedef struct packed {
    logic hit;
    logic miss;
  } judge_evt_t;

endpackage

// File: rtl/key_hit_judge_if.sv
// Player-side bundle: raw keys and tile strobes in, judgement results out.
interface key_hit_judge_if #(
  parameter int LANES   = 4,
  parameter int SCORE_W = 8
);

  logic [LANES-1:0]   key_n;
  logic               tile_valid;
  logic [LANES-1:0]   tile_lanes;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] streak;
  logic               game_over;

  modport master (
    output key_n, tile_valid, tile_lanes,
    input  hit, miss, score, streak, game_over
  );

  modport slave (
    input  key_n, tile_valid, tile_lanes,
    output hit, miss, score, streak, game_over
  );

endinterface

// File: rtl/key_hit_judge_debounce.sv
// One pushbutton lane: 2-flop synchronizer, stable-sample debouncer and a
// registered one-cycle press pulse on the released->pressed transition.
module key_hit_judge_debounce
  import key_hit_judge_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic             deb_last_q, deb_last_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    sync1_d    = ~key_n;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    deb_last_d = deb_q;
    // The counter tracks consecutive samples that disagree with the accepted level.
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = deb_q & ~deb_last_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so each flop samples the pre-edge value of its source.
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_last_q <= 1'b0;
      cnt_q      <= '0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_last_q <= deb_last_d;
      cnt_q      <= cnt_d;
      press_q    <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/key_hit_judge.sv
// Debounces the KEY pushbuttons and judges presses against the row in the hit zone.
// Optional macro STRICT_PRESS_EN: a press with no row armed counts as a miss.
module key_hit_judge
  import key_hit_judge_pkg::*;
#(
  parameter int LANES           = LANES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SCORE_W         = SCORE_W_DEF,
  parameter int MAX_MISSES      = MAX_MISSES_DEF
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  key_hit_judge_if.slave bus
);

  localparam int MISS_W = $clog2(MAX_MISSES + 1);
  localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  logic [LANES-1:0] press;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    key_hit_judge_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (CLOCK_50),
      .rst_n(resetn),
      .key_n(bus.key_n[i]),
      .press(press[i])
    );
  end

  judge_state_e       state_q, state_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               game_over_q, game_over_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] streak_q, streak_d;
  logic [MISS_W-1:0]  misses_q, misses_d;
  judge_evt_t         evt;
  logic               any_press;
  logic               wrong_lane;
  logic               new_row;

  always_comb begin
    any_press  = |press;
    wrong_lane = |(press & ~mask_q);
    new_row    = bus.tile_valid && (bus.tile_lanes != '0);
    evt        = '0;
    state_d    = state_q;
    mask_d     = mask_q;

    // The final miss pulse goes out first; the game ends on the following edge.
    if ((state_q != ST_OVER) && (misses_q >= MISS_LIMIT)) begin
      state_d = ST_OVER;
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef STRICT_PRESS_EN
          evt.miss = any_press;
`endif
          if (new_row) begin
            mask_d  = bus.tile_lanes;
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          // Judge against the old mask before any new row replaces it.
          if (any_press) begin
            if (wrong_lane) evt.miss = 1'b1;
            else            evt.hit  = 1'b1;
          end
          if (bus.tile_valid) begin
            if (!evt.hit) evt.miss = 1'b1;
            mask_d  = bus.tile_lanes;
            state_d = new_row ? ST_ARMED : ST_IDLE;
          end else if (evt.hit) begin
            state_d = ST_IDLE;
          end
        end
        ST_OVER: state_d = ST_OVER;
        default: state_d = ST_IDLE;
      endcase
    end

    hit_d    = evt.hit;
    miss_d   = evt.miss;
    score_d  = score_q;
    streak_d = streak_q;
    misses_d = misses_q;
    if (evt.hit) begin
      if (score_q  != SCORE_MAX) score_d  = score_q + 1'b1;
      if (streak_q != SCORE_MAX) streak_d = streak_q + 1'b1;
    end
    if (evt.miss) begin
      streak_d = '0;
      misses_d = misses_q + 1'b1;
    end
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= '0;
      streak_q    <= '0;
      misses_q    <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      game_over_q <= game_over_d;
      score_q     <= score_d;
      streak_q    <= streak_d;
      misses_q    <= misses_d;
    end
  end

  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.score     = score_q;
  assign bus.streak    = streak_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_key_hit_judge.sv
// Self-checking bench for key_hit_judge with a 4-sample debouncer: directed
// vector table, multi-cycle corner sequences and randomized rows/presses.
module tb_key_hit_judge;

  localparam int LANES = 4;
  localparam int DEB   = 4;
  localparam int SW    = 8;
  localparam int MAXM  = 3;
  localparam int SMAX  = 255;
`ifdef STRICT_PRESS_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  key_hit_judge_if #(.LANES(LANES), .SCORE_W(SW)) bus ();

  key_hit_judge #(
    .LANES(LANES), .DEBOUNCE_CYCLES(DEB), .SCORE_W(SW), .MAX_MISSES(MAXM)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] press;
    logic       tv;
    logic [3:0] lanes;
    logic       e_hit;
    logic       e_miss;
    int         e_score;
    int         e_streak;
    logic       e_go;
  } vec_t;

  vec_t vecs[17];

  // Reference model: the row waiting to be played (0 = none) plus plain counters.
  logic [3:0] m_armed;
  int m_score, m_streak, m_misses;

  // Values captured by apply_txn.
  logic o_hit, o_miss, o_go, o_quiet, o_go_after;
  int   o_score, o_streak;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_armed  = '0;
    m_score  = 0;
    m_streak = 0;
    m_misses = 0;
  endtask

  task automatic do_reset();
    resetn         = 1'b0;
    bus.key_n      = '1;
    bus.tile_valid = 1'b0;
    bus.tile_lanes = '0;
    repeat (3) step();
    resetn = 1'b1;
    step();
    model_reset();
  endtask

  task automatic model_step(input logic [3:0] p, input logic tv, input logic [3:0] l,
                            output logic eh, output logic em);
    eh = 1'b0;
    em = 1'b0;
    if (m_misses < MAXM) begin
      if (m_armed == 4'b0000) begin
        if (STRICT && (p != 4'b0000)) em = 1'b1;
        if (tv) m_armed = l;
      end else begin
        if (p != 4'b0000) begin
          if ((p & ~m_armed) != 4'b0000) em = 1'b1;
          else                           eh = 1'b1;
        end
        if (tv) begin
          if (!eh) em = 1'b1;
          m_armed = l;
        end else if (eh) begin
          m_armed = 4'b0000;
        end
      end
      if (eh) begin
        m_score  = (m_score  < SMAX) ? m_score + 1  : SMAX;
        m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
      end
      if (em) begin
        m_streak = 0;
        m_misses++;
      end
    end
  endtask

  // Clean press of mask p timed so the press is judged in the same cycle as the
  // optional tile strobe; then release and let the debouncer settle.
  task automatic apply_txn(input logic [3:0] p, input logic tv, input logic [3:0] l);
    if (p != 4'b0000) begin
      bus.key_n = ~p;
      repeat (DEB + 3) step();
    end
    bus.tile_valid = tv;
    bus.tile_lanes = tv ? l : 4'($urandom);
    step();
    bus.tile_valid = 1'b0;
    bus.tile_lanes = 4'($urandom);
    o_hit    = bus.hit;
    o_miss   = bus.miss;
    o_score  = int'(bus.score);
    o_streak = int'(bus.streak);
    o_go     = bus.game_over;
    bus.key_n = '1;
    step();
    o_quiet = !bus.hit && !bus.miss;
    repeat (DEB + 4) step();
    o_go_after = bus.game_over;
  endtask

  task automatic model_txn(input string pfx, input logic [3:0] p, input logic tv, input logic [3:0] l);
    logic eh, em, go_before;
    go_before = (m_misses >= MAXM);
    model_step(p, tv, l, eh, em);
    apply_txn(p, tv, l);
    check({pfx, "_hit"},      32'(o_hit),      32'(eh));
    check({pfx, "_miss"},     32'(o_miss),     32'(em));
    check({pfx, "_score"},    32'(o_score),    32'(m_score));
    check({pfx, "_streak"},   32'(o_streak),   32'(m_streak));
    check({pfx, "_go"},       32'(o_go),       32'(go_before));
    check({pfx, "_pulse1"},   32'(o_quiet),    32'(1));
    check({pfx, "_go_after"}, 32'(o_go_after), 32'(m_misses >= MAXM));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_hit, hits, misses, pulses;
    logic [3:0] p, l, m, nm;
    logic tv;

    // Directed vectors from a fresh reset; expectations worked out by hand.
    vecs[0]  = '{4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 0, 0, 1'b0};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 1, 1, 1'b0};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1, 1, 1'b0};
    vecs[3]  = '{4'b1001, 1'b0, 4'b0000, 1'b0, 1'b1, 1, 0, 1'b0};
    vecs[4]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 2, 1, 1'b0};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 2, 1, 1'b0};
    vecs[6]  = '{4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1, 2, 0, 1'b0};
    vecs[7]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0, 3, 1, 1'b0};
    vecs[8]  = '{4'b0000, 1'b1, 4'b0011, 1'b0, 1'b0, 3, 1, 1'b0};
    vecs[9]  = '{4'b0010, 1'b1, 4'b0000, 1'b1, 1'b0, 4, 2, 1'b0};
    vecs[10] = '{4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 4, 2, 1'b0};
    vecs[11] = '{4'b0100, 1'b1, 4'b0001, 1'b1, 1'b0, 5, 3, 1'b0};
    vecs[12] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 6, 4, 1'b0};
    vecs[13] = '{4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 6, 4, 1'b0};
    vecs[14] = '{4'b0010, 1'b1, 4'b1000, 1'b0, 1'b1, 6, 0, 1'b1};
    vecs[15] = '{4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 6, 0, 1'b1};
    vecs[16] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 6, 0, 1'b1};

    bus.key_n      = '1;
    bus.tile_valid = 1'b0;
    bus.tile_lanes = '0;
    do_reset();

    check("reset_hit",       32'(bus.hit),       32'(0));
    check("reset_miss",      32'(bus.miss),      32'(0));
    check("reset_score",     32'(bus.score),     32'(0));
    check("reset_streak",    32'(bus.streak),    32'(0));
    check("reset_game_over", 32'(bus.game_over), 32'(0));

    // Bouncing key on lane 1: one press, judged 8 edges after the level settles.
    bus.tile_valid = 1'b1;
    bus.tile_lanes = 4'b0010;
    step();
    bus.tile_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.key_n[1] = ((c / 2) % 2) != 0;
      step();
    end
    bus.key_n[1] = 1'b0;
    first_hit = 0;
    hits      = 0;
    misses    = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (bus.hit) begin
        hits++;
        if (first_hit == 0) first_hit = n;
      end
      if (bus.miss) misses++;
    end
    check("bounce_latency", 32'(first_hit), 32'(DEB + 4));
    check("bounce_hits",    32'(hits),      32'(1));
    check("bounce_misses",  32'(misses),    32'(0));
    check("bounce_score",   32'(bus.score), 32'(1));
    bus.key_n = '1;
    repeat (10) step();

    // Reset lands exactly when a correct press is about to be judged.
    bus.tile_valid = 1'b1;
    bus.tile_lanes = 4'b0100;
    step();
    bus.tile_valid = 1'b0;
    bus.key_n[2]   = 1'b0;
    repeat (DEB + 3) step();
    resetn    = 1'b0;
    bus.key_n = '1;
    step();
    check("midrst_hit",       32'(bus.hit),       32'(0));
    check("midrst_miss",      32'(bus.miss),      32'(0));
    check("midrst_score",     32'(bus.score),     32'(0));
    check("midrst_streak",    32'(bus.streak),    32'(0));
    check("midrst_game_over", 32'(bus.game_over), 32'(0));
    step();
    resetn = 1'b1;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (bus.hit || bus.miss) pulses++;
    end
    check("midrst_quiet", 32'(pulses), 32'(0));
    model_reset();
    model_txn("idle_press", 4'b0100, 1'b0, 4'b0000);

    // Directed table.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      apply_txn(vecs[i].press, vecs[i].tv, vecs[i].lanes);
      check($sformatf("vec%0d_hit", i),      32'(o_hit),      32'(vecs[i].e_hit));
      check($sformatf("vec%0d_miss", i),     32'(o_miss),     32'(vecs[i].e_miss));
      check($sformatf("vec%0d_score", i),    32'(o_score),    32'(vecs[i].e_score));
      check($sformatf("vec%0d_streak", i),   32'(o_streak),   32'(vecs[i].e_streak));
      check($sformatf("vec%0d_pulse1", i),   32'(o_quiet),    32'(1));
      check($sformatf("vec%0d_go_after", i), 32'(o_go_after), 32'(vecs[i].e_go));
    end

    // Randomized rows and presses against the reference model.
    do_reset();
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 2))
        0:       p = 4'b0000;
        1:       p = 4'(1 << $urandom_range(0, 3));
        default: p = 4'($urandom);
      endcase
      tv = 1'($urandom_range(0, 1));
      l  = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      if ((p == 4'b0000) && !tv) tv = 1'b1;
      model_txn("rand", p, tv, l);
      if ((m_misses >= MAXM) && ($urandom_range(0, 3) == 0)) do_reset();
    end

    // Long hit run: score and streak must saturate, not wrap.
    do_reset();
    m = 4'($urandom_range(1, 15));
    model_txn("sat", 4'b0000, 1'b1, m);
    for (int t = 0; t < 260; t++) begin
      nm = 4'($urandom_range(1, 15));
      model_txn("sat", m, 1'b1, nm);
      m = nm;
    end
    check("sat_score_final",  32'(o_score),  32'(SMAX));
    check("sat_streak_final", 32'(o_streak), 32'(SMAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
